// File: rtl/sw_debounce.sv
// sw_debounce: multi-bit slide-switch debouncer with edge pulses and an
// optional single-entry change-event register.
//
// Build option: define SW_DEBOUNCE_EVT_EN to compile in the event path
// (EVT_VALID / EVT_DATA / EVT_OVF with EVT_READY handshake). Without it the
// event outputs are tied to 0 and EVT_READY is ignored.
//
// Timing: a held SW change reaches SW_DB DEBOUNCE_CYCLES+2 rising edges after
// it is first sampled (2 synchronizer stages plus DEBOUNCE_CYCLES counts).
// SW_RISE/SW_FALL and a new event follow one cycle after SW_DB changes.

module sw_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             EVT_VALID,
  input  logic             EVT_READY,
  output logic [WIDTH-1:0] EVT_DATA,
  output logic             EVT_OVF
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] db_prev;

  // Two-flop synchronizer; only sync_q is used downstream.
  // NOTE: every sequential block uses non-blocking (<=) so all flops sample
  // their inputs from before the edge, giving a true two-stage chain.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= SW;
      sync_q    <= sync_meta;
    end
  end

  // Per-bit stability counter; accepts the synchronized level once it has
  // differed from SW_DB for DEBOUNCE_CYCLES consecutive clocks.
  // NOTE: the counter array is small flop storage, not RAM, so it is cleared
  // on reset like any other state to make the count restart from 0.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      SW_DB <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == SW_DB[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          SW_DB[i] <= sync_q[i];
          cnt[i]   <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          // Saturating guard: the count never wraps.
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered compare of SW_DB against its previous value for edge pulses.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      db_prev <= '0;
      SW_RISE <= '0;
      SW_FALL <= '0;
    end else begin
      db_prev <= SW_DB;
      SW_RISE <= SW_DB & ~db_prev;
      SW_FALL <= ~SW_DB & db_prev;
    end
  end

`ifdef SW_DEBOUNCE_EVT_EN
  logic db_chg;
  logic evt_accept;

  assign db_chg     = |(SW_DB ^ db_prev);
  assign evt_accept = EVT_VALID & EVT_READY;

  // Single-entry event register: a newer change overwrites an unaccepted
  // one (flagging overflow); an accept coinciding with a change hands over
  // the old event and keeps the new one pending with OVF untouched.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      EVT_VALID <= 1'b0;
      EVT_DATA  <= '0;
      EVT_OVF   <= 1'b0;
    end else if (db_chg) begin
      EVT_VALID <= 1'b1;
      EVT_DATA  <= SW_DB;
      if (EVT_VALID && !EVT_READY) EVT_OVF <= 1'b1;
    end else if (evt_accept) begin
      EVT_VALID <= 1'b0;
      EVT_OVF   <= 1'b0;
    end
  end
`else
  logic unused_evt_ready;

  assign unused_evt_ready = EVT_READY;
  assign EVT_VALID        = 1'b0;
  assign EVT_DATA         = '0;
  assign EVT_OVF          = 1'b0;
`endif

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 4, number of independent switch inputs.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable clocks before accepting a change (10 ms at 100 MHz); legal range >= 1.
REQ-003 CLK100MHZ  input  1  system clock, all state on rising edge.
REQ-004 CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-005 SW  input  WIDTH  raw asynchronous slide-switch levels.
REQ-006 SW_DB  output  WIDTH  debounced switch levels.
REQ-007 SW_RISE  output  WIDTH  one-cycle pulse per bit on a debounced 0->1 change.
REQ-008 SW_FALL  output  WIDTH  one-cycle pulse per bit on a debounced 1->0 change.
REQ-009 EVT_VALID  output  1  a change event is pending.
REQ-010 EVT_READY  input  1  consumer accepts the pending event.
REQ-011 EVT_DATA  output  WIDTH  SW_DB value captured by the latest change.
REQ-012 EVT_OVF  output  1  sticky flag: at least one event was overwritten before acceptance.

Function
REQ-013 Each SW bit SHALL pass through a two-flop synchronizer; the second flop (sync bit) is the only value used downstream.
REQ-014 Each bit SHALL have a counter of width $clog2(DEBOUNCE_CYCLES+1) that clears whenever the sync bit equals SW_DB.
REQ-015 While the sync bit differs from SW_DB, the counter SHALL increment by 1 per clock and never wrap.
REQ-016 On the clock edge where the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, SW_DB SHALL take the sync value and the counter SHALL clear.
REQ-017 A held SW change SHALL appear on SW_DB exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES sync cycles SHALL leave SW_DB unchanged and the counter cleared.
REQ-019 SW_RISE/SW_FALL SHALL be asserted in the same cycle SW_DB is one cycle past its new value (registered compare of SW_DB and its previous value), for one cycle only.
REQ-020 Bits SHALL be independent; multiple bits changing on the same edge form a single event.
REQ-021 On any SW_DB change, EVT_DATA SHALL load the new SW_DB and EVT_VALID SHALL be 1 on the following cycle.
REQ-022 EVT_VALID SHALL remain 1 and EVT_DATA stable until a cycle with EVT_VALID=1 and EVT_READY=1 (accept), after which EVT_VALID goes to 0.
REQ-023 A new change while EVT_VALID=1 and no accept SHALL overwrite EVT_DATA with the latest value and set EVT_OVF.
REQ-024 An accept and a new change in the same cycle SHALL consume the old event, keep EVT_VALID=1 with the new EVT_DATA, and leave EVT_OVF unchanged.
REQ-025 EVT_OVF SHALL clear on an accept that is not simultaneous with a new change.
REQ-026 EVT_READY while EVT_VALID=0 SHALL have no effect.

Reset
REQ-027 CPU_RESETN low SHALL immediately clear synchronizers, counters, SW_DB, SW_RISE, SW_FALL, EVT_VALID, EVT_DATA and EVT_OVF to 0, including mid-count or with an event pending.
REQ-028 After release, a switch already high SHALL produce SW_DB=1, SW_RISE pulse and an event after DEBOUNCE_CYCLES+2 edges.

Configuration
REQ-029 With SW_DEBOUNCE_EVT_EN defined, the event path (REQ-021..026) SHALL be compiled in.
REQ-030 Without SW_DEBOUNCE_EVT_EN, EVT_VALID, EVT_DATA and EVT_OVF SHALL be constant 0, EVT_READY ignored, and no event registers instantiated; SW_DB/SW_RISE/SW_FALL unchanged.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, macro defined unless noted)
REQ-031 Reset, SW=4'b0001 held -> SW_DB=4'b0001 at edge 6, SW_RISE=4'b0001 for one cycle, EVT_VALID=1 with EVT_DATA=4'b0001.
REQ-032 SW[2] pulsed high for 3 clocks from SW_DB=0 -> SW_DB stays 4'b0000, no SW_RISE, no event.
REQ-033 Two changes (4'b0001, then 4'b0011) with EVT_READY=0 -> EVT_DATA=4'b0011, EVT_OVF=1; one EVT_READY cycle -> EVT_VALID=0, EVT_OVF=0.
REQ-034 EVT_READY=1 on the same cycle as a new change -> EVT_VALID stays 1, EVT_DATA=new value, EVT_OVF=0.
REQ-035 CPU_RESETN pulsed low mid-count and with event pending -> all outputs 0 asynchronously; count restarts from 0 after release.
REQ-036 Macro undefined, SW toggled -> SW_DB/SW_RISE/SW_FALL as above, EVT_VALID/EVT_DATA/EVT_OVF constant 0.
